// File: rtl/cache_pkg.sv
// Shared types, geometry constants and byte-lane helpers for the direct-mapped data cache.
package cache_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
    localparam int BLOCK_W    = 32;
    localparam int NUM_BLOCKS = 8;
    localparam int MEM_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } cache_state_e;

    // Extract one byte lane of a block; byte 0 sits in the low bits.
    function automatic logic [DATA_W-1:0] byte_select(
        input logic [BLOCK_W-1:0]  block,
        input logic [OFFSET_W-1:0] offset
    );
        logic [DATA_W-1:0] result;
        case (offset)
            2'd0:    result = block[7:0];
            2'd1:    result = block[15:8];
            2'd2:    result = block[23:16];
            2'd3:    result = block[31:24];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

    // Replace one byte lane of a block, leaving the other lanes untouched.
    function automatic logic [BLOCK_W-1:0] byte_insert(
        input logic [BLOCK_W-1:0]  block,
        input logic [OFFSET_W-1:0] offset,
        input logic [DATA_W-1:0]   value
    );
        logic [BLOCK_W-1:0] result;
        result = block;
        case (offset)
            2'd0:    result[7:0]   = value;
            2'd1:    result[15:8]  = value;
            2'd2:    result[23:16] = value;
            2'd3:    result[31:24] = value;
            default: result = block;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cache_array.sv
// Eight-entry valid/dirty/tag/data storage: one combinational read port,
// one synchronous write port (CPU byte store or full-block refill).
module cache_array
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_data,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic                byte_en,
    input  logic [OFFSET_W-1:0] byte_offset,
    input  logic [DATA_W-1:0]   byte_data,
    input  logic                fill_en,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data
);

    logic [NUM_BLOCKS-1:0] valid_r;
    logic [NUM_BLOCKS-1:0] dirty_r;
    logic [TAG_W-1:0]      tag_r  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_r [NUM_BLOCKS];

    // Status bits: cleared on reset, set by refill (clean) or byte store (dirty).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= {NUM_BLOCKS{1'b0}};
            dirty_r <= {NUM_BLOCKS{1'b0}};
        end else if (fill_en) begin
            valid_r[wr_index] <= 1'b1;
            dirty_r[wr_index] <= 1'b0;
        end else if (byte_en) begin
            dirty_r[wr_index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
            dirty_r <= dirty_r;
        end
    end

    // Tag and data payload: not reset, only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_r[wr_index]  <= fill_tag;
            data_r[wr_index] <= fill_data;
        end else if (byte_en) begin
            data_r[wr_index] <= byte_insert(data_r[wr_index], byte_offset, byte_data);
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_dirty = dirty_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_data  = data_r[rd_index];

endmodule

// File: rtl/data_cache_checker.sv
// Protocol checker for the CPU side of data_cache: flags cycles where the
// CPU asserts READ and WRITE together (the cache services these as writes).
module data_cache_checker (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       READ,
    input  logic       WRITE,
    output logic [7:0] conflict_count
);

    logic [7:0] conflict_count_r;

    // Count and report every sampled READ+WRITE collision since the last reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            conflict_count_r <= 8'd0;
        end else if (READ && WRITE) begin
            conflict_count_r <= conflict_count_r + 8'd1;
            $warning("data_cache: READ and WRITE asserted together, treated as write");
        end else begin
            conflict_count_r <= conflict_count_r;
        end
    end

    assign conflict_count = conflict_count_r;

endmodule

// File: rtl/data_cache.sv
// Write-back, write-allocate, direct-mapped data cache between the CPU data
// port and block-wide data memory. Hits complete with no stall; misses run
// WRITEBACK (if dirty) -> FETCH -> UPDATE and then replay as a hit.
module data_cache
    import cache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_W-1:0]     ADDRESS,
    input  logic [DATA_W-1:0]     WRITEDATA,
    output logic [DATA_W-1:0]     READDATA,
    output logic                  BUSYWAIT,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
);

    cache_state_e          state_r;
    cache_state_e          state_next_s;
    logic [INDEX_W-1:0]    index_r;
    logic [TAG_W-1:0]      tag_r;
    logic [BLOCK_W-1:0]    fill_data_r;
    logic                  mem_read_r;
    logic                  mem_write_r;

    logic [TAG_W-1:0]      req_tag_s;
    logic [INDEX_W-1:0]    req_index_s;
    logic [OFFSET_W-1:0]   req_offset_s;
    logic [INDEX_W-1:0]    arr_index_s;
    logic                  ent_valid_s;
    logic                  ent_dirty_s;
    logic [TAG_W-1:0]      ent_tag_s;
    logic [BLOCK_W-1:0]    ent_data_s;
    logic                  idle_s;
    logic                  req_s;
    logic                  hit_s;
    logic                  byte_we_s;
    logic                  fill_we_s;

    assign req_tag_s    = ADDRESS[7:5];
    assign req_index_s  = ADDRESS[4:2];
    assign req_offset_s = ADDRESS[1:0];
    assign idle_s       = (state_r == IDLE);
    assign req_s        = READ | WRITE;

    // Outside IDLE the array is addressed from the latched index so the
    // writeback block and refill target cannot move under the memory.
    always_comb begin
        arr_index_s = index_r;
        if (idle_s) begin
            arr_index_s = req_index_s;
        end else begin
            arr_index_s = index_r;
        end
    end

    cache_array u_array (
        .clk         (CLK),
        .rst_n       (RESET),
        .rd_index    (arr_index_s),
        .rd_valid    (ent_valid_s),
        .rd_dirty    (ent_dirty_s),
        .rd_tag      (ent_tag_s),
        .rd_data     (ent_data_s),
        .wr_index    (arr_index_s),
        .byte_en     (byte_we_s),
        .byte_offset (req_offset_s),
        .byte_data   (WRITEDATA),
        .fill_en     (fill_we_s),
        .fill_tag    (tag_r),
        .fill_data   (fill_data_r)
    );

    assign hit_s     = ent_valid_s && (ent_tag_s == req_tag_s);
    assign byte_we_s = RESET && WRITE && idle_s && hit_s;
    assign fill_we_s = RESET && (state_r == UPDATE);

    // CPU-side response: zero-cycle hits, stall on everything else.
    always_comb begin
        READDATA = 8'h00;
        BUSYWAIT = 1'b0;
        if (RESET && req_s && !(idle_s && hit_s)) begin
            BUSYWAIT = 1'b1;
        end else begin
            BUSYWAIT = 1'b0;
        end
        if (READ && idle_s && hit_s) begin
            READDATA = byte_select(ent_data_s, req_offset_s);
        end else begin
            READDATA = 8'h00;
        end
    end

    // Miss sequencing: next state from current state, hit and memory handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    if (ent_valid_s && ent_dirty_s) begin
                        state_next_s = WRITEBACK;
                    end else begin
                        state_next_s = FETCH;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (!mem_busywait) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = WRITEBACK;
                end
            end
            FETCH: begin
                if (!mem_busywait) begin
                    state_next_s = UPDATE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            UPDATE:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register, request latch, refill capture and registered memory strobes.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r     <= IDLE;
            index_r     <= 3'd0;
            tag_r       <= 3'd0;
            fill_data_r <= 32'h0000_0000;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            mem_read_r  <= (state_next_s == FETCH);
            mem_write_r <= (state_next_s == WRITEBACK);
            if (idle_s) begin
                index_r <= req_index_s;
                tag_r   <= req_tag_s;
            end
            if ((state_r == FETCH) && !mem_busywait) begin
                fill_data_r <= mem_readdata;
            end
        end
    end

    // Memory-side address: victim block address during writeback, requested block otherwise.
    always_comb begin
        mem_address = {tag_r, index_r};
        if (state_r == WRITEBACK) begin
            mem_address = {ent_tag_s, index_r};
        end else begin
            mem_address = {tag_r, index_r};
        end
    end

    assign mem_writedata = ent_data_s;
    assign mem_read      = mem_read_r;
    assign mem_write     = mem_write_r;

endmodule
